layer_neuron_array: RTL
=======================

// Module: layer_neuron_array
// PURPOSE
//   Neuron-side responder to the layer controller's start/active/input/weights interface: one time-multiplexed
//   fully-connected layer of NUM_NEURON neurons. On layer_start it latches the input vector, weight matrix and
//   active mask, accumulates the weighted sums serially over NUM_NEURON cycles (one MAC per neuron), and returns
//   the scaled and saturated sums as per-neuron activation-LUT addresses, with layer_output_valid.
// PARAMETERS
//   NUM_NEURON      6   neurons per layer; also the number of input lanes
//   INPUT_SIZE      9   input lane width, unsigned
//   WEIGHT_SIZE     17  weight width, signed two's complement
//   OUTPUT_SIZE     10  width of the saturated signed sum
//   INPUT_FRACTION  8   fraction bits in the inputs
//   WEIGHT_FRACTION 8   fraction bits in the weights
//   FRACTION_BITS   7   fraction bits kept in the saturated sum
//   ADDR_SIZE       10  output address width per neuron; must equal OUTPUT_SIZE
// PORTS
//   clk                 in   1                               rising-edge clock
//   rst                 in   1                               asynchronous, active-low reset
//   layer_start         in   1                               one-cycle start pulse from the controller
//   active              in   NUM_NEURON                      bit n high = neuron/lane n in use this layer
//   layer_input         in   NUM_NEURON*INPUT_SIZE           lane i at [i*INPUT_SIZE +: INPUT_SIZE]
//   layer_weights       in   NUM_NEURON*NUM_NEURON*WEIGHT_SIZE  w(n,i) at [(n*NUM_NEURON+i)*WEIGHT_SIZE +: WEIGHT_SIZE]
//   layer_output        out  NUM_NEURON*ADDR_SIZE            neuron n LUT address at [n*ADDR_SIZE +: ADDR_SIZE]
//   layer_output_valid  out  NUM_NEURON                      per-neuron valid pulse
//   busy                out  1                               high from the cycle after an accepted start until valid
// BEHAVIOUR
//   Reset: rst low forces IDLE asynchronously. Clears layer_output, layer_output_valid, busy, accumulators,
//     latched operands and the lane counter to 0. Reset may assert mid-computation: the result is discarded
//     and no valid is issued.
//   FSM IDLE -> ACCUM -> DONE -> IDLE.
//   IDLE: layer_start=1 latches layer_input, layer_weights and active; clears all accumulators; sets lane=0;
//     enters ACCUM.
//   ACCUM: one lane per cycle. For every neuron n:
//     acc[n] += (active[i] && active[n]) ? $signed({1'b0,in[i]}) * $signed(w(n,i)) : 0, where i = lane.
//     After lane NUM_NEURON-1, enters DONE.
//   DONE: for each neuron n, s = acc[n] >>> (INPUT_FRACTION+WEIGHT_FRACTION-FRACTION_BITS), using an
//     arithmetic shift that truncates toward -inf.
//     s is saturated to the signed OUTPUT_SIZE range [-2^(OUTPUT_SIZE-1), 2^(OUTPUT_SIZE-1)-1].
//     layer_output[n] <= sat + 2^(OUTPUT_SIZE-1), i.e. offset binary, 0..2^OUTPUT_SIZE-1.
//     layer_output_valid <= latched active for exactly one cycle. Returns to IDLE.
//   Accumulator width: INPUT_SIZE+WEIGHT_SIZE+1+$clog2(NUM_NEURON); it never overflows.
//   Latency: start at cycle T gives layer_output_valid high in cycle T+NUM_NEURON+2 (registered output).
//   Output hold: layer_output holds its value until the next DONE or reset.
//     Lanes of inactive neurons output 512 (zero sum) and their valid bits stay low.
//   busy is high in ACCUM and DONE.
//   Overlapping start: layer_start while busy is ignored; it neither restarts nor gets queued.
//   Start in the valid cycle: layer_start in the same cycle as layer_output_valid (FSM back in IDLE) is
//     accepted normally.
//   Input stability: inputs are sampled only in the start cycle; later changes have no effect on the
//     running layer.
// TESTING
//   1. All active, in=256 (1.0), w(n,i)=256 only for i==n, else 0; start
//      -> after NUM_NEURON+2 cycles valid=6'b111111, every output=640.
//   2. All active, in=256, all w=256
//      -> sum 6.0 saturates to 511, every output=1023; all w=-256 -> sum -6.0 saturates, every output=0.
//   3. active=6'b000111, in=256, all w=256
//      -> valid=6'b000111; neurons 0-2 output 896 (3.0 -> 384+512); neurons 3-5 output 512 with valid low.
//   4. Second start pulse 2 cycles after the first, with different inputs
//      -> ignored; one valid pulse, results match the first operands only.
//   5. rst low during ACCUM lane 3
//      -> outputs, valid and busy are 0 immediately; no valid follows. A new start after reset completes normally.
//   6. in=1, w(n,i)=-1 for all active lanes
//      -> acc=-6, >>>9 gives -1, output=511, which checks the floor-rounding rule.

Source files
------------

// File: rtl/layer_neuron_array.sv
// Time-multiplexed fully-connected layer: one input lane per cycle, all neurons
// accumulate in parallel, then scale and saturate into offset-binary LUT addresses.
module layer_neuron_array #(
  parameter int NUM_NEURON      = 6,
  parameter int INPUT_SIZE      = 9,
  parameter int WEIGHT_SIZE     = 17,
  parameter int OUTPUT_SIZE     = 10,
  parameter int INPUT_FRACTION  = 8,
  parameter int WEIGHT_FRACTION = 8,
  parameter int FRACTION_BITS   = 7,
  parameter int ADDR_SIZE       = 10
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        layer_start,
  input  logic [NUM_NEURON-1:0]                       active,
  input  logic [NUM_NEURON*INPUT_SIZE-1:0]            layer_input,
  input  logic [NUM_NEURON*NUM_NEURON*WEIGHT_SIZE-1:0] layer_weights,
  output logic [NUM_NEURON*ADDR_SIZE-1:0]             layer_output,
  output logic [NUM_NEURON-1:0]                       layer_output_valid,
  output logic                                        busy
);

  localparam int ACC_W  = INPUT_SIZE + WEIGHT_SIZE + 1 + $clog2(NUM_NEURON);
  localparam int PROD_W = INPUT_SIZE + 1 + WEIGHT_SIZE;
  localparam int SHIFT  = INPUT_FRACTION + WEIGHT_FRACTION - FRACTION_BITS;
  localparam int LANE_W = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_NEURON - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t state, state_nx;

  logic        [INPUT_SIZE-1:0]  in_q  [NUM_NEURON];
  logic signed [WEIGHT_SIZE-1:0] w_q   [NUM_NEURON][NUM_NEURON];
  logic        [NUM_NEURON-1:0]  act_q;
  logic signed [ACC_W-1:0]       acc   [NUM_NEURON];
  logic        [LANE_W-1:0]      lane;

  logic signed [INPUT_SIZE:0]    x;
  logic signed [PROD_W-1:0]      prod  [NUM_NEURON];
  logic signed [ACC_W-1:0]       sh    [NUM_NEURON];
  logic        [ADDR_SIZE-1:0]   res   [NUM_NEURON];

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (layer_start) state_nx = ACCUM;
      ACCUM:   if (lane == LAST_LANE) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Current lane's input times each neuron's weight, gated by both active bits
  always_comb begin
    x = $signed({1'b0, in_q[lane]});
    for (int n = 0; n < NUM_NEURON; n++) begin
      prod[n] = '0;
      if (act_q[lane] && act_q[n])
        prod[n] = PROD_W'(x) * PROD_W'(w_q[n][lane]);
    end
  end

  // Floor shift, then saturate; offset binary is the sign bit inverted
  always_comb begin
    for (int n = 0; n < NUM_NEURON; n++) begin
      sh[n] = acc[n] >>> SHIFT;
      if (&sh[n][ACC_W-1:OUTPUT_SIZE-1] || ~|sh[n][ACC_W-1:OUTPUT_SIZE-1])
        res[n] = {~sh[n][OUTPUT_SIZE-1], sh[n][OUTPUT_SIZE-2:0]};
      else if (sh[n][ACC_W-1])
        res[n] = '0;
      else
        res[n] = '1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_q              <= '0;
      lane               <= '0;
      layer_output       <= '0;
      layer_output_valid <= '0;
      for (int n = 0; n < NUM_NEURON; n++) begin
        in_q[n] <= '0;
        acc[n]  <= '0;
        for (int i = 0; i < NUM_NEURON; i++) w_q[n][i] <= '0;
      end
    end else begin
      layer_output_valid <= '0;
      unique case (state)
        IDLE: begin
          if (layer_start) begin
            act_q <= active;
            lane  <= '0;
            for (int n = 0; n < NUM_NEURON; n++) begin
              in_q[n] <= layer_input[n*INPUT_SIZE +: INPUT_SIZE];
              acc[n]  <= '0;
              for (int i = 0; i < NUM_NEURON; i++)
                w_q[n][i] <= layer_weights[(n*NUM_NEURON+i)*WEIGHT_SIZE +: WEIGHT_SIZE];
            end
          end
        end
        ACCUM: begin
          lane <= lane + 1'b1;
          for (int n = 0; n < NUM_NEURON; n++)
            acc[n] <= acc[n] + {{(ACC_W-PROD_W){prod[n][PROD_W-1]}}, prod[n]};
        end
        DONE: begin
          lane               <= '0;
          layer_output_valid <= act_q;
          for (int n = 0; n < NUM_NEURON; n++)
            layer_output[n*ADDR_SIZE +: ADDR_SIZE] <= res[n];
        end
        default: lane <= '0;
      endcase
    end
  end

endmodule
